// File: rtl/uart_tx_unit_if.sv
// Write-side handshake of the UART transmitter: the holding-register
// write strobe, its data word, and the occupancy flag returned to the writer.
interface uart_tx_unit_if #(
  parameter int NB_DATA = 8
);
  logic               wr;
  logic [NB_DATA-1:0] data_in;
  logic               full;

  modport master (output wr, output data_in, input full);
  modport slave  (input wr, input data_in, output full);
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: one-word holding register in front of a start/data/stop
// shifter paced by a 16x-baud s_tick strobe; tx is registered and idles high.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (tx=0) for 16 ticks
// DATA  | NB_DATA bits, LSB first, 16 ticks each
// STOP  | stop bit (tx=1) for SB_TICK ticks, then one-clk tx_done_tick
module uart_tx_unit #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_tick,
  uart_tx_unit_if.slave  bus,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);

  // The bit counter doubles as the upper digits of the stop-bit counter,
  // so it must be wide enough for both the data index and SB_TICK/16.
  localparam int BIT_MAX = ((NB_DATA - 1) > ((SB_TICK - 1) / 16)) ?
                           (NB_DATA - 1) : ((SB_TICK - 1) / 16);
  localparam int BW = (BIT_MAX > 0) ? $clog2(BIT_MAX + 1) : 1;
  localparam logic [BW-1:0]   BIT_LAST  = BW'(NB_DATA - 1);
  localparam logic [BW+3:0]   STOP_LAST = (BW + 4)'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] hold_q, hold_d;
  logic               full_q, full_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               load;
  logic [BW+3:0]      stop_cnt;

  assign stop_cnt = {bit_q, tick_q};
  assign load     = (state_q == IDLE) && full_q;

  // A write landing in the same cycle as the load still sees full=1 and is dropped.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (load) begin
      full_d = 1'b0;
    end else if (bus.wr && !full_q) begin
      full_d = 1'b1;
      hold_d = bus.data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q) begin
          shift_d = hold_q;
          tick_d  = 4'd0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) state_d = DATA;
        end
      end
      DATA: begin
        if (s_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (stop_cnt == STOP_LAST) begin
            tick_d  = 4'd0;
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            {bit_d, tick_d} = stop_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the state being entered so the line changes on the same edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.full     = full_q;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: a table of words with hand-built frames,
// plus back-to-back, overflow, mid-frame reset, idle-tick and 2-stop-bit cases.
module tb_uart_tx_unit;

  logic clk;
  logic rst_n;
  logic s_tick;
  logic tx, tx_busy, tx_done;
  logic tx32, busy32, done32;

  uart_tx_unit_if #(.NB_DATA(8)) bus_if ();
  uart_tx_unit_if #(.NB_DATA(8)) bus32_if ();

  uart_tx_unit #(.NB_DATA(8), .SB_TICK(16)) u_dut (
    .clk(clk), .reset(rst_n), .s_tick(s_tick), .bus(bus_if.slave),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done)
  );

  uart_tx_unit #(.NB_DATA(8), .SB_TICK(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .s_tick(s_tick), .bus(bus32_if.slave),
    .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32)
  );

  typedef struct {
    logic [9:0] bits;
    int         nticks;
    bit         uniform;
    int         gap;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tick_period = 4;
  int tick_phase  = 0;
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase++;
      if (tick_phase >= tick_period) tick_phase = 0;
      s_tick = (tick_phase == 0);
    end
  end

  // Frame monitor: one tx sample per consumed tick while busy, bits taken mid-bit.
  logic   samples[$];
  frame_t frames[$];
  frame_t mon_f;
  int     gap_cnt = 0, cur_gap = 0, idle_bad = 0, dbl_done = 0;
  logic   prev_busy = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      samples.delete();
      gap_cnt   = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (!tx_busy && tx !== 1'b1) idle_bad++;
      if (tx_done && prev_done) dbl_done++;
      if (tx_busy && !prev_busy) cur_gap = gap_cnt;
      if (!tx_busy) gap_cnt++;
      else gap_cnt = 0;
      if (tx_busy && s_tick) samples.push_back(tx);
      if (tx_done) begin
        mon_f.nticks  = samples.size();
        mon_f.uniform = (mon_f.nticks == 160);
        mon_f.bits    = '0;
        mon_f.gap     = cur_gap;
        if (mon_f.nticks == 160) begin
          for (int k = 0; k < 10; k++) begin
            mon_f.bits[k] = samples[16*k+8];
            for (int j = 0; j < 16; j++)
              if (samples[16*k+j] !== samples[16*k]) mon_f.uniform = 1'b0;
          end
        end
        frames.push_back(mon_f);
        samples.delete();
      end
      prev_busy = tx_busy;
      prev_done = tx_done;
    end
  end

  int   bcnt32 = 0, ones32 = 0, done32_cnt = 0, last_b32 = 0, last_ones32 = 0;
  logic prev_busy32 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy32 = 1'b0;
    end else begin
      if (busy32 && !prev_busy32) begin
        bcnt32 = 0;
        ones32 = 0;
      end
      if (busy32) begin
        bcnt32++;
        if (tx32 === 1'b1) ones32++;
        else ones32 = 0;
      end
      if (done32) begin
        done32_cnt++;
        last_b32    = bcnt32;
        last_ones32 = ones32;
      end
      prev_busy32 = busy32;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clks(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic write(input logic [7:0] d);
    bus_if.wr      = 1'b1;
    bus_if.data_in = d;
    tick_clk();
    bus_if.wr      = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (frames.size() < n && c < budget) begin
      tick_clk();
      c++;
    end
    if (frames.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got %0d frames, expected %0d", name, frames.size(), n);
    end
  endtask

  task automatic check_frame(input string name, input logic [9:0] exp_bits);
    frame_t f;
    if (frames.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no frame, expected bits 0x%0h", name, exp_bits);
    end else begin
      f = frames.pop_front();
      check({name, " bits"}, 32'(f.bits), 32'(exp_bits));
      check({name, " ticks"}, f.nticks, 160);
      check({name, " hold"}, 32'(f.uniform), 1);
    end
  endtask

  vec_t vecs[7];
  frame_t fb;

  initial begin
    // bit i = i-th level on the line: start(0), d0..d7, stop(1)
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h5A, 10'b1010110100};
    vecs[5] = '{8'h80, 10'b1100000000};
    vecs[6] = '{8'h01, 10'b1000000010};

    bus_if.wr = 1'b0;    bus_if.data_in = '0;
    bus32_if.wr = 1'b0;  bus32_if.data_in = '0;
    rst_n = 1'b0;
    run_clks(3);
    check("rst tx", 32'(tx), 1);
    check("rst busy", 32'(tx_busy), 0);
    check("rst full", 32'(bus_if.full), 0);
    check("rst done", 32'(tx_done), 0);
    rst_n = 1'b1;
    run_clks(2);

    tick_period = 2;
    run_clks(100);
    check("idle tx", 32'(tx), 1);
    check("idle busy", 32'(tx_busy), 0);
    check("idle frames", frames.size(), 0);

    tick_period = 4;
    for (int v = 0; v < 7; v++) begin
      write(vecs[v].data);
      check($sformatf("vec%0d full after wr", v), 32'(bus_if.full), 1);
      tick_clk();
      check($sformatf("vec%0d full after load", v), 32'(bus_if.full), 0);
      check($sformatf("vec%0d busy", v), 32'(tx_busy), 1);
      wait_frames(1, 1000, $sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), vecs[v].exp_bits);
      run_clks(3);
    end

    write(8'h3C);
    run_clks(100);
    check("b2b busy", 32'(tx_busy), 1);
    write(8'hC3);
    check("b2b full", 32'(bus_if.full), 1);
    wait_frames(2, 1600, "b2b");
    check_frame("b2b first", 10'b1001111000);
    if (frames.size() > 0) begin
      fb = frames[0];
      check("b2b idle gap", fb.gap, 1);
    end
    check_frame("b2b second", 10'b1110000110);
    run_clks(50);
    check("b2b done count", frames.size(), 0);

    write(8'h11);
    tick_clk();
    write(8'h22);
    write(8'h33);
    check("ovf full", 32'(bus_if.full), 1);
    wait_frames(2, 1600, "ovf");
    check_frame("ovf first", 10'b1000100010);
    check_frame("ovf second", 10'b1001000100);
    run_clks(700);
    check("ovf no third", frames.size(), 0);
    check("ovf idle", 32'(tx_busy), 0);

    write(8'hA5);
    tick_clk();
    write(8'h77);
    run_clks(280);
    check("rstmid busy", 32'(tx_busy), 1);
    check("rstmid pending", 32'(bus_if.full), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid tx", 32'(tx), 1);
    check("rstmid busy0", 32'(tx_busy), 0);
    check("rstmid full", 32'(bus_if.full), 0);
    check("rstmid done", 32'(tx_done), 0);
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
    run_clks(10);
    check("rstmid no frame", frames.size(), 0);
    write(8'h5A);
    wait_frames(1, 1000, "post rst");
    check_frame("post rst", 10'b1010110100);
    run_clks(700);
    check("post rst pending lost", frames.size(), 0);

    tick_period = 1;
    run_clks(3);
    bus32_if.wr      = 1'b1;
    bus32_if.data_in = 8'h5A;
    tick_clk();
    bus32_if.wr      = 1'b0;
    for (int c = 0; c < 400 && done32_cnt == 0; c++) tick_clk();
    check("sb32 done count", done32_cnt, 1);
    check("sb32 frame clks", last_b32, 176);
    check("sb32 stop clks", last_ones32, 32);
    run_clks(5);
    check("sb32 tx idle", 32'(tx32), 1);

    check("no tx low while idle", idle_bad, 0);
    check("done pulse width", dbl_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
